ula_arbiter: RTL and testbench
==============================

Name: ula_arbiter

Overview:
Shares the single 32-bit ULA between two requesters: port 0 (execute stage) and port 1 (address/branch unit).
- Arbitrates round-robin with a req/ack handshake.
- Registers the winning operands and opcode onto the ULA inputs.
- Captures ULA Out/Flag one cycle later and returns them tagged with the requester ID.
- Sits between the pipeline stages and the ULA instance in the processor top level.

Parameters:
WIDTH, 32, operand/result width (matches ULA A/B/Out)
OPW, 5, opcode width (matches ULA opcode)

Ports:
clock  in  1  system clock, all logic rising-edge
reset  in  1  synchronous, active-low reset (sampled on rising edge of clock)
req0  in  1  requester 0 operation request
a0  in  WIDTH  requester 0 operand A
b0  in  WIDTH  requester 0 operand B
op0  in  OPW  requester 0 opcode
ack0  out  1  one-cycle pulse: requester 0 operation accepted
req1  in  1  requester 1 operation request
a1  in  WIDTH  requester 1 operand A
b1  in  WIDTH  requester 1 operand B
op1  in  OPW  requester 1 opcode
ack1  out  1  one-cycle pulse: requester 1 operation accepted
ula_a  out  WIDTH  registered operand to ULA A
ula_b  out  WIDTH  registered operand to ULA B
ula_opcode  out  OPW  registered opcode to ULA opcode
ula_out  in  WIDTH  ULA Out (combinational from ula_a/ula_b/ula_opcode)
ula_flag  in  1  ULA Flag
res_valid  out  1  one-cycle pulse: result fields valid
res_data  out  WIDTH  captured ULA Out
res_flag  out  1  captured ULA Flag
res_id  out  1  requester that owns the result
busy  out  1  high while an operation occupies the ULA

Behaviour:
- Reset (reset==0 at rising edge) values:
  - state=IDLE, priority pointer=0.
  - ula_a, ula_b, ula_opcode, res_data = 0.
  - ack0, ack1, res_valid, res_flag, res_id, busy = 0.
- Reset has priority over every other event. Reset mid-operation discards the in-flight op: no res_valid, no ack.
- FSM states: IDLE, EXEC.
- IDLE, no req: remain in IDLE. Outputs hold, except that ack*/res_valid are forced to 0.
- IDLE, any req at edge T:
  - Grant one requester (g).
  - Latch a_g/b_g/op_g into ula_a/ula_b/ula_opcode.
  - ack_g=1 and busy=1 for the cycle after T.
  - Next state EXEC.
- Arbitration:
  - Only one req: grant it.
  - Both req: grant the requester named by the priority pointer.
  - After any grant, the pointer = 1-g (round-robin).
  - Reset pointer=0, so port 0 wins the first tie.
- EXEC at edge T+1:
  - res_data<=ula_out, res_flag<=ula_flag, res_id<=g, res_valid=1 for one cycle.
  - busy<=0, ack<=0, state<=IDLE.
  - Requests are not sampled in EXEC.
- Latency: request sampled at edge T produces a result at edge T+1, visible after T+1. Ack and result are in consecutive cycles.
- Throughput: at most one op per 2 cycles. Back-to-back ops are accepted at edges T, T+2, T+4...
- Requester rules:
  - Hold req and operands stable until ack is seen.
  - In the ack cycle, drop req or present the next op (sampled no earlier than T+2).
  - A requester not granted keeps req high; it is guaranteed a grant at the next IDLE sample.
- ula_a/ula_b/ula_opcode hold their last latched values between operations. They change only on a grant.
- res_data/res_flag/res_id hold between pulses.
- ack0 and ack1 are never high together. res_valid is never high in the same cycle as any ack.
- No arithmetic is performed here. Widths pass through unchanged, with no extension or truncation.

Test Plan:
- Reset: hold reset=0 for 2 edges with req0=req1=1 -> all outputs 0, no ack. Release -> first grant is port 0 (ack0=1, ack1=0).
- Single op: req0=1, a0=32'h5, b0=32'h0, op0=5'b00001 -> next cycle ack0=1, busy=1, ula_a=32'h5, ula_opcode=5'b00001. Bench drives ula_out=32'h6, ula_flag=1 -> following cycle res_valid=1, res_data=32'h6, res_flag=1, res_id=0, busy=0.
- Contention: req0=req1=1 held continuously with distinct operands -> grant order 0,1,0,1 at edges T, T+2, T+4, T+6. res_id alternates 0,1,0,1 and each result matches its own operands' ula_out.
- Port 1 alone: req1=1, a1=32'h1, b1=32'hFFFFFFFF -> ack1=1, ula_b=32'hFFFFFFFF. Then a tie -> port 0 wins (pointer=0 after port-1 grant).
- Reset mid-op: assert reset in the EXEC cycle -> no res_valid, busy=0, ula_a=0; next request is accepted normally.
- Stable-hold check: change a0 while req0 is high but not yet granted (req1 has priority) -> the value latched at the port-0 grant equals a0 at that edge, not the earlier value.

Source files
------------

// File: rtl/ula_arbiter.sv
// ---------------------------------------------------------------------------
// ula_arbiter
// Shares one ULA between two requesters (port 0: execute stage, port 1:
// address/branch unit). A request sampled in IDLE is granted round-robin,
// its operands/opcode are registered onto the ULA inputs and acked. One
// cycle later the ULA result is captured and returned tagged with the
// owner's ID. At most one operation every two cycles.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   req0/a0/b0/op0/ack0   requester 0 request, operands, opcode, accept pulse
//   req1/a1/b1/op1/ack1   requester 1 request, operands, opcode, accept pulse
//   ula_a/ula_b/ula_opcode registered operands and opcode driven to the ULA
//   ula_out/ula_flag      combinational ULA result and flag
//   res_valid             one-cycle pulse, result fields valid
//   res_data/res_flag     captured ULA result and flag
//   res_id                requester that owns the result
//   busy                  high while an operation occupies the ULA
// ---------------------------------------------------------------------------
module ula_arbiter #(
    parameter int WIDTH = 32,
    parameter int OPW   = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [OPW-1:0]   op0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [OPW-1:0]   op1,
    output logic             ack1,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [OPW-1:0]   ula_opcode,
    input  logic [WIDTH-1:0] ula_out,
    input  logic             ula_flag,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t           state_q;
    logic             ptr_q;       // requester that wins the next tie
    logic             gid_q;       // owner of the operation in flight
    logic [WIDTH-1:0] ula_a_q;
    logic [WIDTH-1:0] ula_b_q;
    logic [OPW-1:0]   ula_op_q;
    logic             ack0_q;
    logic             ack1_q;
    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic             res_flag_q;
    logic             res_id_q;
    logic             busy_q;

    logic             any_req;
    logic             grant_d;     // winner if requests are sampled this edge

    // A lone request wins outright; a tie goes to the pointer.
    always_comb begin
        any_req = req0 | req1;
        if (req0 && req1) begin
            grant_d = ptr_q;
        end else begin
            grant_d = req1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            gid_q       <= 1'b0;
            ula_a_q     <= '0;
            ula_b_q     <= '0;
            ula_op_q    <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            res_id_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ack0_q      <= 1'b0;
                    ack1_q      <= 1'b0;
                    res_valid_q <= 1'b0;
                    if (any_req) begin
                        ula_a_q  <= grant_d ? a1  : a0;
                        ula_b_q  <= grant_d ? b1  : b0;
                        ula_op_q <= grant_d ? op1 : op0;
                        ack0_q   <= ~grant_d;
                        ack1_q   <= grant_d;
                        busy_q   <= 1'b1;
                        gid_q    <= grant_d;
                        ptr_q    <= ~grant_d;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    // ULA inputs were registered last edge, so its output is
                    // settled now; requests are deliberately ignored here.
                    res_data_q  <= ula_out;
                    res_flag_q  <= ula_flag;
                    res_id_q    <= gid_q;
                    res_valid_q <= 1'b1;
                    ack0_q      <= 1'b0;
                    ack1_q      <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign ula_a      = ula_a_q;
    assign ula_b      = ula_b_q;
    assign ula_opcode = ula_op_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_flag   = res_flag_q;
    assign res_id     = res_id_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ula_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ula_arbiter
// Self-checking bench for ula_arbiter. Directed scenarios followed by a
// randomized run checked against a transaction-level model (an operation
// occupies two cycles; ties alternate).
// ---------------------------------------------------------------------------
module tb_ula_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] a0, b0, a1, b1;
    logic [4:0]  op0, op1;
    logic        ack0, ack1;
    logic [31:0] ula_a, ula_b;
    logic [4:0]  ula_opcode;
    logic [31:0] ula_out;
    logic        ula_flag;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_flag;
    logic        res_id;
    logic        busy;

    logic        ovr_en;
    logic [31:0] ovr_out;
    logic        ovr_flag;

    int total = 0;
    int bad   = 0;

    ula_arbiter #(.WIDTH(32), .OPW(5)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1), .ack1(ack1),
        .ula_a(ula_a), .ula_b(ula_b), .ula_opcode(ula_opcode),
        .ula_out(ula_out), .ula_flag(ula_flag),
        .res_valid(res_valid), .res_data(res_data), .res_flag(res_flag),
        .res_id(res_id), .busy(busy)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] ula_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [4:0] op);
        return (a ^ {b[15:0], b[31:16]}) + {27'd0, op};
    endfunction

    function automatic logic ula_flag_f(input logic [31:0] a, input logic [31:0] b);
        return a < b;
    endfunction

    // Stand-in ULA: combinational from the arbiter's registered inputs.
    always_comb begin
        if (ovr_en) begin
            ula_out  = ovr_out;
            ula_flag = ovr_flag;
        end else begin
            ula_out  = ula_f(ula_a, ula_b, ula_opcode);
            ula_flag = ula_flag_f(ula_a, ula_b);
        end
    end

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0; req0 = 1'b1; req1 = 1'b1;
        a0 = 32'hA0A0_0001; b0 = 32'h0B0B_0002; op0 = 5'd3;
        a1 = 32'h1111_2222; b1 = 32'h3333_4444; op1 = 5'd7;
        cyc(); cyc();
        total++;
        if ({ack0, ack1, res_valid, res_flag, res_id, busy} !== 6'b0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {ack0, ack1, res_valid, res_flag, res_id, busy});
        end
        total++;
        if ({ula_a, ula_b, ula_opcode, res_data} !== 101'b0) begin
            bad++;
            $display("FAIL reset_data: ula_a=%h ula_b=%h op=%h res_data=%h expected all 0",
                     ula_a, ula_b, ula_opcode, res_data);
        end
        reset = 1'b1;
        cyc();
        total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || ula_a !== 32'hA0A0_0001) begin
            bad++;
            $display("FAIL reset_first_tie: ack0=%b ack1=%b ula_a=%h expected 1 0 a0a00001",
                     ack0, ack1, ula_a);
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();   // pointer now favours port 1
    endtask

    task automatic test_single();
        ovr_en = 1'b1; ovr_out = 32'h6; ovr_flag = 1'b1;
        req0 = 1'b1; a0 = 32'h5; b0 = 32'h0; op0 = 5'b00001;
        cyc();
        total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || busy !== 1'b1 || ula_a !== 32'h5 ||
            ula_b !== 32'h0 || ula_opcode !== 5'b00001 || res_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_ack: ack0=%b ack1=%b busy=%b ula_a=%h ula_b=%h op=%b rv=%b",
                     ack0, ack1, busy, ula_a, ula_b, ula_opcode, res_valid);
        end
        req0 = 1'b0;
        cyc();
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'h6 || res_flag !== 1'b1 || res_id !== 1'b0 ||
            busy !== 1'b0 || ack0 !== 1'b0) begin
            bad++;
            $display("FAIL single_result: rv=%b data=%h flag=%b id=%b busy=%b ack0=%b expected 1 6 1 0 0 0",
                     res_valid, res_data, res_flag, res_id, busy, ack0);
        end
        ovr_en = 1'b0;
        cyc();
        total++;
        if (res_valid !== 1'b0 || res_data !== 32'h6 || ula_a !== 32'h5) begin
            bad++;
            $display("FAIL single_hold: rv=%b data=%h ula_a=%h expected 0 6 5",
                     res_valid, res_data, ula_a);
        end
    endtask

    task automatic test_port1_tie();
        req1 = 1'b1; a1 = 32'h1; b1 = 32'hFFFF_FFFF; op1 = 5'd2;
        cyc();
        total++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || ula_b !== 32'hFFFF_FFFF || ula_a !== 32'h1) begin
            bad++;
            $display("FAIL port1_ack: ack1=%b ack0=%b ula_b=%h ula_a=%h", ack1, ack0, ula_b, ula_a);
        end
        req0 = 1'b1; a0 = 32'hDEAD_0000; b0 = 32'h0000_BEEF; op0 = 5'd9;
        a1 = 32'h7777_0000; b1 = 32'h2; op1 = 5'd4;
        cyc();
        total++;
        if (res_valid !== 1'b1 || res_id !== 1'b1 ||
            res_data !== ula_f(32'h1, 32'hFFFF_FFFF, 5'd2) || res_flag !== 1'b1) begin
            bad++;
            $display("FAIL port1_result: rv=%b id=%b data=%h flag=%b", res_valid, res_id, res_data, res_flag);
        end
        cyc();
        total++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0 || ula_a !== 32'hDEAD_0000) begin
            bad++;
            $display("FAIL tie_after_port1: ack0=%b ack1=%b ula_a=%h expected 1 0 dead0000",
                     ack0, ack1, ula_a);
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();   // pointer now favours port 1
    endtask

    task automatic test_reset_midop();
        req0 = 1'b1; a0 = 32'h1234_5678; b0 = 32'h9; op0 = 5'd1;
        cyc();
        total++;
        if (ack0 !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL midop_grant: ack0=%b busy=%b expected 1 1", ack0, busy);
        end
        req0 = 1'b0; reset = 1'b0;
        cyc();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || ula_a !== 32'h0 || ack0 !== 1'b0 ||
            res_data !== 32'h0) begin
            bad++;
            $display("FAIL midop_reset: rv=%b busy=%b ula_a=%h ack0=%b data=%h expected 0 0 0 0 0",
                     res_valid, busy, ula_a, ack0, res_data);
        end
        reset = 1'b1;
        cyc();
        total++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midop_no_late_result: rv=%b busy=%b", res_valid, busy);
        end
        req1 = 1'b1; a1 = 32'h0F0F_0F0F; b1 = 32'h0000_0100; op1 = 5'd17;
        cyc();
        total++;
        if (ack1 !== 1'b1 || ula_a !== 32'h0F0F_0F0F || ula_opcode !== 5'd17) begin
            bad++;
            $display("FAIL midop_after_ack: ack1=%b ula_a=%h op=%0d", ack1, ula_a, ula_opcode);
        end
        req1 = 1'b0;
        cyc();
        total++;
        if (res_valid !== 1'b1 || res_id !== 1'b1 ||
            res_data !== ula_f(32'h0F0F_0F0F, 32'h0000_0100, 5'd17)) begin
            bad++;
            $display("FAIL midop_after_result: rv=%b id=%b data=%h", res_valid, res_id, res_data);
        end
        cyc();          // pointer favours port 0 (last grant was port 1)
    endtask

    task automatic test_contention();
        logic [31:0] ca[2][2];
        logic [31:0] cb[2][2];
        logic [4:0]  co[2][2];
        int          nxt[2];
        int          g;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 2; k++) begin
                ca[p][k] = $urandom; cb[p][k] = $urandom; co[p][k] = 5'($urandom_range(0, 31));
            end
            nxt[p] = 0;
        end
        req0 = 1'b1; a0 = ca[0][0]; b0 = cb[0][0]; op0 = co[0][0];
        req1 = 1'b1; a1 = ca[1][0]; b1 = cb[1][0]; op1 = co[1][0];
        for (int k = 0; k < 4; k++) begin
            g = k % 2;
            cyc();
            total++;
            if (ack0 !== (g == 0) || ack1 !== (g == 1) || ula_a !== ca[g][nxt[g]] ||
                ula_b !== cb[g][nxt[g]] || ula_opcode !== co[g][nxt[g]]) begin
                bad++;
                $display("FAIL contention_grant%0d: ack0=%b ack1=%b ula_a=%h expected port %0d a=%h",
                         k, ack0, ack1, ula_a, g, ca[g][nxt[g]]);
            end
            nxt[g]++;
            if (g == 0) begin
                if (nxt[0] < 2) begin a0 = ca[0][nxt[0]]; b0 = cb[0][nxt[0]]; op0 = co[0][nxt[0]]; end
                else req0 = 1'b0;
            end else begin
                if (nxt[1] < 2) begin a1 = ca[1][nxt[1]]; b1 = cb[1][nxt[1]]; op1 = co[1][nxt[1]]; end
                else req1 = 1'b0;
            end
            cyc();
            total++;
            if (res_valid !== 1'b1 || res_id !== 1'(g) ||
                res_data !== ula_f(ca[g][nxt[g]-1], cb[g][nxt[g]-1], co[g][nxt[g]-1]) ||
                res_flag !== ula_flag_f(ca[g][nxt[g]-1], cb[g][nxt[g]-1]) ||
                ack0 !== 1'b0 || ack1 !== 1'b0) begin
                bad++;
                $display("FAIL contention_result%0d: rv=%b id=%b data=%h expected id %0d data %h",
                         k, res_valid, res_id, res_data, g,
                         ula_f(ca[g][nxt[g]-1], cb[g][nxt[g]-1], co[g][nxt[g]-1]));
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc();          // pointer favours port 0
    endtask

    task automatic test_stable_hold();
        // One port-0 op so that port 1 wins the following tie.
        req0 = 1'b1; a0 = 32'h55; b0 = 32'h1; op0 = 5'd0;
        cyc();
        req0 = 1'b0;
        cyc();
        req0 = 1'b1; a0 = 32'hAAAA_0001; b0 = 32'h3; op0 = 5'd5;
        req1 = 1'b1; a1 = 32'hBBBB_0002; b1 = 32'h4; op1 = 5'd6;
        cyc();
        total++;
        if (ack1 !== 1'b1 || ack0 !== 1'b0 || ula_a !== 32'hBBBB_0002) begin
            bad++;
            $display("FAIL hold_port1_first: ack1=%b ack0=%b ula_a=%h", ack1, ack0, ula_a);
        end
        req1 = 1'b0;
        a0 = 32'hCCCC_0003;
        cyc();
        a0 = 32'hEEEE_0004;
        cyc();
        total++;
        if (ack0 !== 1'b1 || ula_a !== 32'hEEEE_0004) begin
            bad++;
            $display("FAIL hold_latch_value: ack0=%b ula_a=%h expected 1 eeee0004", ack0, ula_a);
        end
        req0 = 1'b0;
        cyc(); cyc();   // pointer favours port 1
    endtask

    task automatic test_random();
        logic        pend[2];
        logic [31:0] pa[2];
        logic [31:0] pb[2];
        logic [4:0]  po[2];
        int          ptr_m;
        bit          exec_m;
        bit          e_ack;
        int          g;
        logic [31:0] e_data;
        logic        e_flag;
        int          e_id;
        pend[0] = 1'b0; pend[1] = 1'b0;
        pa[0] = '0; pa[1] = '0; pb[0] = '0; pb[1] = '0; po[0] = '0; po[1] = '0;
        ptr_m = 1; exec_m = 1'b0; e_data = '0; e_flag = 1'b0; e_id = 0; g = 0;
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    pa[p] = $urandom; pb[p] = $urandom; po[p] = 5'($urandom_range(0, 31));
                end
            end
            req0 = pend[0]; a0 = pa[0]; b0 = pb[0]; op0 = po[0];
            req1 = pend[1]; a1 = pa[1]; b1 = pb[1]; op1 = po[1];
            e_ack = 1'b0;
            if (!exec_m && (pend[0] || pend[1])) begin
                e_ack = 1'b1;
                if (pend[0] && pend[1]) g = ptr_m;
                else g = pend[1] ? 1 : 0;
            end
            cyc();
            total++;
            if (ack0 !== (e_ack && g == 0) || ack1 !== (e_ack && g == 1) ||
                res_valid !== exec_m || busy !== e_ack) begin
                bad++;
                $display("FAIL rand_ctrl@%0d: ack0=%b ack1=%b rv=%b busy=%b expected ack=%b g=%0d rv=%b",
                         n, ack0, ack1, res_valid, busy, e_ack, g, exec_m);
            end
            if (exec_m) begin
                total++;
                if (res_data !== e_data || res_flag !== e_flag || res_id !== 1'(e_id)) begin
                    bad++;
                    $display("FAIL rand_result@%0d: data=%h flag=%b id=%b expected %h %b %0d",
                             n, res_data, res_flag, res_id, e_data, e_flag, e_id);
                end
                exec_m = 1'b0;
            end else if (e_ack) begin
                total++;
                if (ula_a !== pa[g] || ula_b !== pb[g] || ula_opcode !== po[g]) begin
                    bad++;
                    $display("FAIL rand_operands@%0d: a=%h b=%h op=%h expected %h %h %h",
                             n, ula_a, ula_b, ula_opcode, pa[g], pb[g], po[g]);
                end
                e_data = ula_f(pa[g], pb[g], po[g]);
                e_flag = ula_flag_f(pa[g], pb[g]);
                e_id   = g;
                pend[g] = 1'b0;
                ptr_m  = 1 - g;
                exec_m = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        cyc(); cyc();
    endtask

    initial begin
        ovr_en = 1'b0; ovr_out = '0; ovr_flag = 1'b0;
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        test_reset();
        test_single();
        test_port1_tie();
        test_reset_midop();
        test_contention();
        test_stable_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
